// File: rtl/ixc_nib4_bus_ctrl_if.sv
// Request/response and nibble-bus signal bundle for ixc_nib4_bus_ctrl.
// The master modport is the engine side; slave is the requester/bind side.
interface ixc_nib4_bus_ctrl_if #(
  parameter int WORD_W = 16
);
  logic              tx_valid;
  logic              tx_ready;
  logic [WORD_W-1:0] tx_data;
  logic              tx_rsp;
  logic              rx_valid;
  logic [WORD_W-1:0] rx_data;
  logic              err_timeout;
  logic              err_unsol;
  logic [3:0]        bus_o;
  logic              bus_oe;
  logic              bus_strobe_o;
  logic [3:0]        bus_i;
  logic              bus_strobe_i;

  modport master (
    input  tx_valid, tx_data, tx_rsp, bus_i, bus_strobe_i,
    output tx_ready, rx_valid, rx_data, err_timeout, err_unsol,
           bus_o, bus_oe, bus_strobe_o
  );

  modport slave (
    output tx_valid, tx_data, tx_rsp, bus_i, bus_strobe_i,
    input  tx_ready, rx_valid, rx_data, err_timeout, err_unsol,
           bus_o, bus_oe, bus_strobe_o
  );
endinterface

// File: rtl/ixc_nib4_bus_ctrl.sv
// Word-to-nibble transaction engine: serialises a request word LS nibble
// first, optionally turns the bus around and collects a response word.
// Bus pins are split (out/oe/in) so the bind stage owns inout resolution.
module ixc_nib4_bus_ctrl #(
  parameter int WORD_W   = 16,
  parameter int TURN_CYC = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ixc_nib4_bus_ctrl_if.master  bus
);

  localparam int NIB = WORD_W / 4;
  localparam int NW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int IW  = $clog2(TIMEOUT + 1);

  localparam logic [NW-1:0] LAST_NIB  = NW'(NIB - 1);
  localparam logic [3:0]    LAST_TURN = 4'(TURN_CYC - 1);
  localparam logic [IW-1:0] LAST_IDLE = IW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_TX, S_TURN, S_RX} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] tx_word;
  logic              tx_rsp_q;
  logic [WORD_W-1:0] rx_shift;
  logic [WORD_W-1:0] rx_merge;
  logic [NW-1:0]     nib_cnt;
  logic [NW-1:0]     rx_cnt;
  logic [3:0]        turn_cnt;
  logic [IW-1:0]     idle_cnt;
  logic              accept, tx_last, turn_last, rx_last, rx_abort;

  // Transition qualifiers shared by the FSM and the datapath.
  always_comb begin
    accept    = (state_q == S_IDLE) && bus.tx_valid;
    tx_last   = (state_q == S_TX)   && (nib_cnt == LAST_NIB);
    turn_last = (state_q == S_TURN) && (turn_cnt == LAST_TURN);
    rx_last   = (state_q == S_RX)   && bus.bus_strobe_i && (rx_cnt == LAST_NIB);
    rx_abort  = (state_q == S_RX)   && !bus.bus_strobe_i && (idle_cnt == LAST_IDLE);
  end

  // Response word with the currently strobed nibble merged in; lets the
  // final nibble land in rx_data on the same edge it is sampled.
  always_comb begin
    rx_merge = rx_shift;
    rx_merge[{rx_cnt, 2'b00} +: 4] = bus.bus_i;
  end

  // State register; async reset drops bus_oe immediately via the decode below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept)              state_d = S_TX;
      S_TX:   if (tx_last)             state_d = tx_rsp_q ? S_TURN : S_IDLE;
      S_TURN: if (turn_last)           state_d = S_RX;
      S_RX:   if (rx_last || rx_abort) state_d = S_IDLE;
      default:                         state_d = S_IDLE;
    endcase
  end

  // State-decoded bus and handshake outputs; bus_o is forced to 0 off-drive.
  always_comb begin
    bus.tx_ready     = (state_q == S_IDLE);
    bus.bus_oe       = (state_q == S_TX);
    bus.bus_strobe_o = (state_q == S_TX);
    bus.bus_o        = '0;
    if (state_q == S_TX) bus.bus_o = tx_word[{nib_cnt, 2'b00} +: 4];
  end

  // Datapath, counters and registered status pulses. Each counter is held at
  // zero outside the state that uses it, so it restarts on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_word         <= '0;
      tx_rsp_q        <= 1'b0;
      rx_shift        <= '0;
      nib_cnt         <= '0;
      rx_cnt          <= '0;
      turn_cnt        <= '0;
      idle_cnt        <= '0;
      bus.rx_valid    <= 1'b0;
      bus.rx_data     <= '0;
      bus.err_timeout <= 1'b0;
      bus.err_unsol   <= 1'b0;
    end else begin
      bus.rx_valid    <= rx_last;
      bus.err_timeout <= rx_abort;
      bus.err_unsol   <= bus.bus_strobe_i && (state_q != S_RX);
      if (rx_last) bus.rx_data <= rx_merge;
      if (accept) begin
        tx_word  <= bus.tx_data;
        tx_rsp_q <= bus.tx_rsp;
      end
      nib_cnt  <= (state_q == S_TX)   ? nib_cnt + 1'b1  : '0;
      turn_cnt <= (state_q == S_TURN) ? turn_cnt + 1'b1 : '0;
      if (state_q == S_RX) begin
        if (bus.bus_strobe_i) begin
          rx_shift <= rx_merge;
          rx_cnt   <= rx_cnt + 1'b1;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        rx_cnt   <= '0;
        idle_cnt <= '0;
      end
    end
  end

endmodule
